// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring shift-subtract unsigned divider, one quotient bit per clock.
// A start/busy/done handshake matches the neighbouring multiplier in the arithmetic unit.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_r;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_d;
  logic [CntW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_div_by_zero;

  logic [WIDTH:0]    w_t;
  logic              w_ge;
  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_r_next;
  logic [WIDTH-1:0]  w_q_next;

  // Comparison is WIDTH+1 bits; when T >= D the difference is below D, so its
  // low WIDTH bits are exact and R never needs the extra bit stored.
  always_comb begin
    w_t      = {r_r, r_q[WIDTH-1]};
    w_ge     = (w_t >= {1'b0, r_d});
    w_diff   = w_t[WIDTH-1:0] - r_d;
    w_r_next = w_ge ? w_diff : w_t[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_r           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            if (divisor == '0) begin
              r_state       <= StDone;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
              r_d     <= divisor;
              r_q     <= dividend;
              r_r     <= '0;
              r_cnt   <= CntW'(WIDTH);
            end
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StCalc: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CntW'(1)) begin
            r_state       <= StDone;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_quotient    <= w_q_next;
            r_remainder   <= w_r_next;
            r_div_by_zero <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8) with hand-computed expectations.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the start edge (T0 + 1 time unit).
  task automatic launch(input logic [7:0] dd, input logic [7:0] dv);
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    tick();
    start = 1'b0;
  endtask

  // lat counts edges after the start edge until done is seen; nb counts busy samples.
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      tick();
      lat++;
    end
  endtask

  int lat, nb, cnt, gap;
  int unsigned rdd, rdv;

  initial begin
    #12;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_quot", 32'(quotient), 0);
    check("reset_rem", 32'(remainder), 0);
    check("reset_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(8'd100, 8'd7);
    check("100_7_busy_after_start", 32'(busy), 1);
    wait_done(lat, nb);
    check("100_7_latency", lat, 8);
    check("100_7_busy_cycles", nb, 8);
    check("100_7_quot", 32'(quotient), 14);
    check("100_7_rem", 32'(remainder), 2);
    check("100_7_dbz", 32'(div_by_zero), 0);
    check("100_7_busy_at_done", 32'(busy), 0);
    tick();
    check("100_7_done_one_cycle", 32'(done), 0);
    check("100_7_quot_hold", 32'(quotient), 14);

    launch(8'd255, 8'd1);
    check("255_1_quot_hold_calc", 32'(quotient), 14);
    wait_done(lat, nb);
    check("255_1_latency", lat, 8);
    check("255_1_quot", 32'(quotient), 255);
    check("255_1_rem", 32'(remainder), 0);

    launch(8'd5, 8'd9);
    wait_done(lat, nb);
    check("5_9_quot", 32'(quotient), 0);
    check("5_9_rem", 32'(remainder), 5);

    launch(8'h2A, 8'd0);
    wait_done(lat, nb);
    check("div0_latency", lat, 0);
    check("div0_busy_cycles", nb, 0);
    check("div0_quot", 32'(quotient), 8'hFF);
    check("div0_rem", 32'(remainder), 8'h2A);
    check("div0_dbz", 32'(div_by_zero), 1);
    tick();
    check("div0_done_one_cycle", 32'(done), 0);
    check("div0_dbz_hold", 32'(div_by_zero), 1);

    launch(8'd12, 8'd4);
    check("12_4_dbz_hold_calc", 32'(div_by_zero), 1);
    wait_done(lat, nb);
    check("12_4_quot", 32'(quotient), 3);
    check("12_4_rem", 32'(remainder), 0);
    check("12_4_dbz_cleared", 32'(div_by_zero), 0);

    // Start pulse mid-CALC must be ignored.
    launch(8'd200, 8'd10);
    tick();
    tick();
    tick();
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd3;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) cnt++;
      tick();
    end
    check("ignore_done_count", cnt, 1);
    check("ignore_quot", 32'(quotient), 20);
    check("ignore_rem", 32'(remainder), 0);

    // Back-to-back: start held high through DONE.
    launch(8'd60, 8'd7);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_first_seen", 32'(done), 1);
    check("b2b_first_quot", 32'(quotient), 8);
    check("b2b_first_rem", 32'(remainder), 4);
    tick();
    start = 1'b0;
    check("b2b_no_idle_gap_busy", 32'(busy), 1);
    check("b2b_done_single", 32'(done), 0);
    gap = 1;
    while (!done && gap < 40) begin
      tick();
      gap++;
    end
    check("b2b_done_spacing", gap, 9);
    check("b2b_second_quot", 32'(quotient), 4);
    check("b2b_second_rem", 32'(remainder), 1);

    // Asynchronous reset mid-CALC.
    launch(8'd200, 8'd10);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quot", 32'(quotient), 0);
    check("rst_rem", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("rst_no_done_after", cnt, 0);
    launch(8'd17, 8'd5);
    wait_done(lat, nb);
    check("17_5_latency", lat, 8);
    check("17_5_quot", 32'(quotient), 3);
    check("17_5_rem", 32'(remainder), 2);

    // Random sweep against the division identity.
    for (int i = 0; i < 40; i++) begin
      rdd = $urandom_range(0, 255);
      rdv = $urandom_range(1, 255);
      launch(8'(rdd), 8'(rdv));
      wait_done(lat, nb);
      check("rand_identity", 32'(quotient) * rdv + 32'(remainder), rdd);
      check("rand_rem_lt_div", 32'(32'(remainder) < rdv), 1);
      check("rand_quot", 32'(quotient), rdd / rdv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
